// File: rtl/sensor_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sensor_debounce_pkg
// Shared constants for the field-switch input conditioner.
//   N             : number of filtered inputs
//   IDX_*         : fixed bit positions of each switch inside raw_in/clean
//   TICK_DIV_DEF  : default clock cycles per sample tick
//   DEB_TICKS_DEF : default consecutive disagreeing ticks to accept a level
//   cnt_width()   : width of a per-bit debounce counter (never below 1)
// ---------------------------------------------------------------------------
package sensor_debounce_pkg;

   localparam int N = 6;

   localparam int IDX_L  = 0;
   localparam int IDX_M  = 1;
   localparam int IDX_H  = 2;
   localparam int IDX_US = 3;
   localparam int IDX_UA = 4;
   localparam int IDX_T  = 5;

   localparam int TICK_DIV_DEF  = 50000;
   localparam int DEB_TICKS_DEF = 20;

   typedef logic [N-1:0] sensor_vec_t;

   // The counter only has to reach DEB_TICKS-1. With DEB_TICKS=1 it never
   // leaves zero, but a zero-width vector is illegal, so keep one bit.
   function automatic int cnt_width(input int deb_ticks);
      return (deb_ticks > 1) ? $clog2(deb_ticks) : 1;
   endfunction

endpackage

// File: rtl/sensor_debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
// Conditions one raw switch input: two-flop synchroniser, tick-sampled
// agreement counter, debounced level, one-cycle change strobe and a
// combinational glitch flag for the shared glitch counter.
//   clock   : system clock, rising edge
//   Rst     : asynchronous active-low reset
//   raw     : unsynchronised switch input
//   tick    : one-cycle sample enable from the shared divider
//   clean   : debounced level
//   changed : high for the single cycle in which clean shows a new value
//   glitch  : high on a tick that aborts a partly counted transition
// ---------------------------------------------------------------------------
module debounce_cell
   import sensor_debounce_pkg::*;
#(
   parameter int DEB_TICKS = DEB_TICKS_DEF
) (
   input  logic clock,
   input  logic Rst,
   input  logic raw,
   input  logic tick,
   output logic clean,
   output logic changed,
   output logic glitch
);

   localparam int CW = cnt_width(DEB_TICKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

   logic          sync_meta;
   logic          sync_q;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          clean_next;
   logic          changed_next;

   // Two-flop synchroniser; sync_q is raw delayed by two cycles.
   always_ff @(posedge clock or negedge Rst) begin
      if (!Rst) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync_q    <= sync_meta;
      end
   end

   // Filter decision, only acted upon on tick cycles. Agreement with a
   // non-zero count means a transition was abandoned: that is a glitch.
   // The final disagreeing tick accepts the new level and fires the strobe.
   always_comb begin
      cnt_next     = cnt;
      clean_next   = clean;
      changed_next = 1'b0;
      glitch       = 1'b0;
      if (tick) begin
         if (sync_q == clean) begin
            if (cnt != '0) begin
               cnt_next = '0;
               glitch   = 1'b1;
            end
         end else if (cnt == CNT_LAST) begin
            clean_next   = sync_q;
            cnt_next     = '0;
            changed_next = 1'b1;
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end
   end

   // State register for the counter, the clean level and the strobe.
   always_ff @(posedge clock or negedge Rst) begin
      if (!Rst) begin
         cnt     <= '0;
         clean   <= 1'b0;
         changed <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         clean   <= clean_next;
         changed <= changed_next;
      end
   end

endmodule

// File: rtl/sensor_debounce.sv
// ---------------------------------------------------------------------------
// sensor_debounce
// Input conditioner for the irrigation controller's level probes (L, M, H)
// and soil/air/timer inputs (Us, Ua, T). Owns the shared sample-tick divider,
// one debounce_cell per input, the pooled saturating glitch counter and the
// tank-level consistency flag.
//   clock      : system clock, rising edge
//   Rst        : asynchronous active-low reset
//   raw_in     : unsynchronised switch inputs (bit map in the package)
//   clean      : debounced levels
//   changed    : one-cycle strobe per bit when clean flips
//   level_err  : registered (H & ~M) | (M & ~L) of clean
//   glitch_cnt : saturating count of aborted transitions, all bits pooled
// ---------------------------------------------------------------------------
module sensor_debounce
   import sensor_debounce_pkg::*;
#(
   parameter int TICK_DIV  = TICK_DIV_DEF,
   parameter int DEB_TICKS = DEB_TICKS_DEF
) (
   input  logic         clock,
   input  logic         Rst,
   input  logic [N-1:0] raw_in,
   output logic [N-1:0] clean,
   output logic [N-1:0] changed,
   output logic         level_err,
   output logic [7:0]   glitch_cnt
);

   localparam int DW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic          tick;
   sensor_vec_t   glitch;
   logic [3:0]    glitch_sum;
   logic [8:0]    glitch_total;
   logic [7:0]    glitch_next;

   // Free-running sample divider; all cells sample on the same cycle.
   always_ff @(posedge clock or negedge Rst) begin
      if (!Rst) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   for (genvar i = 0; i < N; i++) begin : g_cell
      debounce_cell #(
         .DEB_TICKS (DEB_TICKS)
      ) u_cell (
         .clock   (clock),
         .Rst     (Rst),
         .raw     (raw_in[i]),
         .tick    (tick),
         .clean   (clean[i]),
         .changed (changed[i]),
         .glitch  (glitch[i])
      );
   end

   // Several bits can abort on the same tick, so add them all and clamp
   // the result at 255 instead of letting the counter wrap.
   always_comb begin
      glitch_sum = '0;
      for (int i = 0; i < N; i++) begin
         glitch_sum = glitch_sum + 4'(glitch[i]);
      end
      glitch_total = {1'b0, glitch_cnt} + 9'(glitch_sum);
      glitch_next  = (glitch_total > 9'd255) ? 8'hFF : glitch_total[7:0];
   end

   // Glitch counter and level consistency flag. A probe reading "wet" above
   // a "dry" probe is physically impossible; the flag only reports it.
   always_ff @(posedge clock or negedge Rst) begin
      if (!Rst) begin
         glitch_cnt <= 8'h00;
         level_err  <= 1'b0;
      end else begin
         glitch_cnt <= glitch_next;
         level_err  <= (clean[IDX_H] & ~clean[IDX_M]) |
                       (clean[IDX_M] & ~clean[IDX_L]);
      end
   end

endmodule

// File: tb/tb_sensor_debounce.sv
// ---------------------------------------------------------------------------
// tb_sensor_debounce
// Self-checking bench for sensor_debounce with TICK_DIV=4, DEB_TICKS=3.
// A behavioural model tracks, per input, the run of consecutive tick samples
// that disagree with the accepted level; outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_sensor_debounce;

   localparam int N         = 6;
   localparam int TICK_DIV  = 4;
   localparam int DEB_TICKS = 3;

   logic         clock;
   logic         rst_n;
   logic [N-1:0] raw_in;
   logic [N-1:0] clean;
   logic [N-1:0] changed;
   logic         level_err;
   logic [7:0]   glitch_cnt;

   int errors = 0;
   int checks = 0;

   sensor_debounce #(
      .TICK_DIV  (TICK_DIV),
      .DEB_TICKS (DEB_TICKS)
   ) dut (
      .clock      (clock),
      .Rst        (rst_n),
      .raw_in     (raw_in),
      .clean      (clean),
      .changed    (changed),
      .level_err  (level_err),
      .glitch_cnt (glitch_cnt)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural model state
   int           m_edges;
   logic [N-1:0] m_hist[$];
   int           m_run [N];
   logic [N-1:0] m_clean;
   logic [N-1:0] m_changed;
   logic         m_err;
   int           m_glitch;

   // Model: edges are counted from reset release; every TICK_DIV-th edge is a
   // sample edge, and the sample seen there is the raw value present two
   // edges earlier (zero before that, as the synchroniser was cleared).
   always @(posedge clock or negedge rst_n) begin
      logic [N-1:0] s;
      int           g;
      if (!rst_n) begin
         m_edges   = 0;
         m_hist.delete();
         for (int i = 0; i < N; i++) m_run[i] = 0;
         m_clean   = '0;
         m_changed = '0;
         m_err     = 1'b0;
         m_glitch  = 0;
      end else begin
         m_edges++;
         m_hist.push_back(raw_in);
         if (m_hist.size() > 3) void'(m_hist.pop_front());
         m_err     = (m_clean[2] && !m_clean[1]) || (m_clean[1] && !m_clean[0]);
         m_changed = '0;
         if (m_edges % TICK_DIV == 0) begin
            s = (m_hist.size() == 3) ? m_hist[0] : '0;
            g = 0;
            for (int i = 0; i < N; i++) begin
               if (s[i] != m_clean[i]) begin
                  m_run[i]++;
                  if (m_run[i] == DEB_TICKS) begin
                     m_clean[i]   = s[i];
                     m_changed[i] = 1'b1;
                     m_run[i]     = 0;
                  end
               end else if (m_run[i] > 0) begin
                  g++;
                  m_run[i] = 0;
               end
            end
            m_glitch = (m_glitch + g > 255) ? 255 : m_glitch + g;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clock) begin
      checkOutput("clean",      32'(clean),      32'(m_clean));
      checkOutput("changed",    32'(changed),    32'(m_changed));
      checkOutput("level_err",  32'(level_err),  32'(m_err));
      checkOutput("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
   end

   // Drive raw_in and advance whole cycles; inputs move 2 ns after the edge.
   task automatic applyStimulus(input logic [N-1:0] v, input int cycles);
      raw_in = v;
      repeat (cycles) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic doReset(input logic [N-1:0] v);
      rst_n  = 1'b0;
      raw_in = v;
      repeat (3) begin
         @(posedge clock);
         #2;
      end
      checkOutput("rst_clean",   32'(clean),      32'h0);
      checkOutput("rst_changed", 32'(changed),    32'h0);
      checkOutput("rst_glitch",  32'(glitch_cnt), 32'h0);
      rst_n = 1'b1;
   endtask

   // Count edges after release until clean matches target (bounded).
   task automatic waitClean(input logic [N-1:0] mask, input logic [N-1:0] target,
                            output int edges);
      edges = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock);
         #2;
         if ((clean & mask) == target) begin
            edges = k;
            break;
         end
      end
   endtask

   initial begin
      int edges;
      int strobes;
      int g0;
      rst_n  = 1'b0;
      raw_in = '0;
      @(posedge clock);
      #2;

      // Reset with all inputs high: first accept lands on the third tick.
      doReset(6'h3F);
      waitClean(6'h3F, 6'h3F, edges);
      checkOutput("reset_accept_edges", 32'(edges), 32'd12);
      checkOutput("reset_changed", 32'(changed), 32'h3F);
      applyStimulus(6'h3F, 1);
      checkOutput("reset_changed_off", 32'(changed), 32'h0);
      checkOutput("reset_level_err", 32'(level_err), 32'h0);

      // Bounce on L: sampled pattern never gives three agreeing ticks.
      doReset(6'h00);
      applyStimulus(6'h00, 20);
      strobes = 0;
      for (int k = 0; k < 40; k++) begin
         applyStimulus({5'b0, ((k / 3) % 2) == 0}, 1);
         if (changed[0]) strobes++;
      end
      for (int k = 0; k < 20; k++) begin
         applyStimulus(6'h01, 1);
         if (changed[0]) strobes++;
      end
      checkOutput("bounce_strobes", 32'(strobes), 32'd1);
      checkOutput("bounce_clean", 32'(clean[0]), 32'd1);
      checkOutput("bounce_glitch_nonzero", 32'(glitch_cnt != 8'h00), 32'd1);

      // Spike on T: one aborted transition, no strobe.
      g0 = int'(glitch_cnt);
      strobes = 0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus((k < 5) ? 6'h21 : 6'h01, 1);
         if (changed[5]) strobes++;
      end
      checkOutput("spike_strobes", 32'(strobes), 32'd0);
      checkOutput("spike_clean", 32'(clean[5]), 32'd0);
      checkOutput("spike_glitch", 32'(glitch_cnt), 32'(g0 + 1));

      // Level error: H and L without M, then M restores consistency.
      doReset(6'h00);
      applyStimulus(6'h00, 20);
      raw_in = 6'h05;
      waitClean(6'h04, 6'h04, edges);
      checkOutput("lerr_seen", 32'(edges > 0), 32'd1);
      checkOutput("lerr_lag", 32'(level_err), 32'd0);
      applyStimulus(6'h05, 1);
      checkOutput("lerr_set", 32'(level_err), 32'd1);
      raw_in = 6'h07;
      waitClean(6'h02, 6'h02, edges);
      checkOutput("lerr_m_seen", 32'(edges > 0), 32'd1);
      checkOutput("lerr_still", 32'(level_err), 32'd1);
      applyStimulus(6'h07, 1);
      checkOutput("lerr_clear", 32'(level_err), 32'd0);

      // Saturation: 300 spikes on T.
      doReset(6'h00);
      applyStimulus(6'h00, 20);
      for (int k = 0; k < 300; k++) begin
         applyStimulus(6'h20, 5);
         applyStimulus(6'h00, 7);
      end
      checkOutput("sat_glitch", 32'(glitch_cnt), 32'd255);

      // Reset two ticks into an L transition; window restarts afterwards.
      doReset(6'h00);
      applyStimulus(6'h00, 20);
      raw_in = 6'h01;
      edges = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock);
         #2;
         if (m_run[0] == 2) begin
            edges = k;
            break;
         end
      end
      checkOutput("mid_reached", 32'(edges > 0), 32'd1);
      checkOutput("mid_clean_before", 32'(clean[0]), 32'd0);
      doReset(6'h01);
      waitClean(6'h01, 6'h01, edges);
      checkOutput("mid_restart_edges", 32'(edges), 32'd12);

      applyStimulus(raw_in, 5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog so a stuck run still ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/sensor_debounce.md
# sensor_debounce

Input conditioner for the irrigation controller's field switches: level probes H, M, L and the soil/air/timer inputs Us, Ua, T. Each raw input is synchronised, filtered against bounce and spikes on a shared sample tick, and exposed as a clean level plus a one-cycle change strobe. The block also flags an inconsistent tank-level pattern and counts rejected glitches. It sits between the package pins and the level/error and irrigation logic, which consume only its clean outputs.

## Interface
- N, 6, number of filtered inputs; bit map fixed by package: 0=L, 1=M, 2=H, 3=Us, 4=Ua, 5=T
- TICK_DIV, 50000, clock cycles per sample tick (≥2)
- DEB_TICKS, 20, consecutive disagreeing ticks needed to accept a new level (≥1)
- clock  in  1  system clock, all logic on rising edge
- Rst  in  1  reset, asynchronous, active-low
- raw_in  in  N  unsynchronised switch inputs
- clean  out  N  debounced levels
- changed  out  N  one-cycle strobe per bit when clean flips
- level_err  out  1  registered: (H & ~M) | (M & ~L) on clean
- glitch_cnt  out  8  saturating count of aborted transitions, all bits pooled

## Operation
- Reset values: clean=0, changed=0, level_err=0, glitch_cnt=0; synchroniser flops, per-bit counters and tick divider all 0.
- Synchroniser: two flops per bit; sync[i] is raw_in[i] delayed 2 cycles.
- Tick divider: counts 0..TICK_DIV-1, wraps; tick=1 for the single cycle where count==TICK_DIV-1.
- Per-bit filter, evaluated only on tick cycles using that cycle's sync[i]:
  - sync==clean, cnt==0: hold.
  - sync==clean, cnt>0: cnt←0, glitch event.
  - sync!=clean, cnt<DEB_TICKS-1: cnt←cnt+1.
  - sync!=clean, cnt==DEB_TICKS-1: clean←sync, cnt←0, changed[i]=1 next cycle only.
- Counter width: clog2(DEB_TICKS), minimum 1.
- glitch_cnt increments by the number of bits with a glitch event on that tick, saturating at 255, never wraps.
- level_err is recomputed every cycle from clean; it is a flag only and does not gate clean.

## Timing
- Raw edge held steady: clean flips between 2+(DEB_TICKS-1)·TICK_DIV+1 and 2+DEB_TICKS·TICK_DIV+1 cycles after the edge, depending on tick phase.
- changed[i] asserts in the same cycle that clean[i] shows the new value, for exactly 1 cycle.
- level_err lags clean by 1 cycle.
- Sync edge landing on a tick cycle is sampled on that tick.
- Pulses shorter than DEB_TICKS ticks never reach clean.
- Multiple bits may flip on the same tick; their strobes are simultaneous.
- Rst asserted mid-count: all state clears immediately. After release, high inputs need a full debounce window to show on clean.
- DEB_TICKS=1: accept on the first disagreeing tick. Glitch events are then impossible.

## Structure
- Shared package: N, bit indices IDX_L/IDX_M/IDX_H/IDX_US/IDX_UA/IDX_T, default TICK_DIV and DEB_TICKS.
- Sub-module debounce_cell: synchroniser, counter, clean, changed and glitch flag for one bit. It is instantiated N times.
- Top level holds the tick divider, the glitch adder/saturator and level_err.

## Test plan
All scenarios use TICK_DIV=4, DEB_TICKS=3.
- Reset check: Rst low with raw_in=6'h3F, then released. clean=0 and glitch_cnt=0 during reset. clean=6'h3F within 2+3·4+1=15 cycles after release, with changed=6'h3F for one cycle.
- Bounce: raw L toggles every 3 cycles for 40 cycles, then held 1. clean[0] flips exactly once, after the final hold. glitch_cnt>0.
- Spike: 5-cycle high pulse on T. clean[5] stays 0, changed stays 0, glitch_cnt increments by 1.
- Level error: hold H=1, M=0, L=1. After debounce, level_err=1 one cycle after clean[2] rises. Raising M clears it after debounce+1.
- Saturation: 300 spikes. glitch_cnt ends at 255.
- Mid-count reset: assert Rst two ticks into an L transition. clean[0] stays 0, and the full 3-tick window restarts after release.
